sum_frame_accumulator: RTL and testbench

//  Sequential consumer placed directly downstream of the 16-bit ripple-carry adder (17-bit result: sum[15:0] + carry-out).

---
 rtl/sum_acc_pkg.sv | 20 ++
 rtl/acc_add_sat.sv | 25 ++
 rtl/sum_frame_accumulator.sv | 123 ++++++++++++
 tb/tb_sum_frame_accumulator.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sum_acc_pkg.sv
// Shared types, default widths and helpers for the adder-result frame accumulator.
// Optional feature macro: SUM_ACC_SATURATE_EN (saturating accumulation).
package sum_acc_pkg;

    localparam int IN_W_DEF  = 17;
    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // A programmed length of zero is treated as a single-beat frame.
    function automatic logic [CNT_W_DEF-1:0] eff_len(input logic [CNT_W_DEF-1:0] len);
        return (len == '0) ? CNT_W_DEF'(1) : len;
    endfunction

endpackage

// File: rtl/acc_add_sat.sv
// Combinational ACC_W adder with carry-out; clamps to all-ones on overflow
// when SUM_ACC_SATURATE_EN is defined, otherwise wraps modulo 2^ACC_W.
module acc_add_sat
    import sum_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [ACC_W-1:0] i_b,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_cout
);

    logic [ACC_W:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b};
    assign o_cout = w_full[ACC_W];

`ifdef SUM_ACC_SATURATE_EN
    assign o_sum = w_full[ACC_W] ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
    assign o_sum = w_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_frame_accumulator.sv
// Accumulates frames of 17-bit adder results and presents total/count/overflow
// on a valid/ready output. Optional macro: SUM_ACC_SATURATE_EN.
module sum_frame_accumulator
    import sum_acc_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [CNT_W-1:0] frame_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic [1:0]       o_dbg_state
);

    // Handshake: a beat moves when in_valid & in_ready in the same cycle; the
    // result moves when out_valid & out_ready. Outputs are held while stalled.

    state_t             r_state, w_state_nxt;
    logic [ACC_W-1:0]   r_acc, w_acc_nxt;
    logic [CNT_W-1:0]   r_count, w_count_nxt;
    logic [CNT_W-1:0]   r_len, w_len_nxt;
    logic               r_ovf, w_ovf_nxt;

    logic               w_in_xfer;
    logic               w_out_xfer;
    logic [ACC_W-1:0]   w_beat_ext;
    logic [ACC_W-1:0]   w_sum;
    logic               w_cout;
    logic [CNT_W-1:0]   w_count_inc;
    logic [CNT_W-1:0]   w_first_len;

    assign in_ready    = (r_state != HOLD);
    assign out_valid   = (r_state == HOLD);
    assign out_acc     = r_acc;
    assign out_count   = r_count;
    assign out_ovf     = r_ovf;
    assign o_dbg_state = r_state;

    assign w_in_xfer   = in_valid & in_ready;
    assign w_out_xfer  = out_valid & out_ready;
    assign w_beat_ext  = {{(ACC_W-IN_W){1'b0}}, in_data};
    assign w_count_inc = r_count + 1'b1;
    assign w_first_len = eff_len(frame_len);

    acc_add_sat #(.ACC_W(ACC_W)) u_add (
        .i_a    (r_acc),
        .i_b    (w_beat_ext),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_count_nxt = r_count;
        w_len_nxt   = r_len;
        w_ovf_nxt   = r_ovf;
        if (clear) begin
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_in_xfer) begin
                        w_len_nxt   = w_first_len;
                        w_acc_nxt   = w_beat_ext;
                        w_count_nxt = CNT_W'(1);
                        w_ovf_nxt   = 1'b0;
                        w_state_nxt = (w_first_len == CNT_W'(1)) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_in_xfer) begin
                        w_acc_nxt   = w_sum;
                        w_count_nxt = w_count_inc;
                        w_ovf_nxt   = r_ovf | w_cout;
                        if (w_count_inc == r_len) begin
                            w_state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Results stay visible after handoff until the next first beat.
                    if (w_out_xfer) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_count <= '0;
            r_len   <= CNT_W'(1);
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_count <= w_count_nxt;
            r_len   <= w_len_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

endmodule

// File: tb/tb_sum_frame_accumulator.sv
// Directed bench for sum_frame_accumulator: table of frames plus hand-written
// sequences for gaps/backpressure, clear and asynchronous reset.
module tb_sum_frame_accumulator;
    import sum_acc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [16:0] in_data = '0;
    logic [7:0]  frame_len = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_acc;
    logic [7:0]  out_count;
    logic        out_ovf;
    logic [1:0]  o_dbg_state;

    int total = 0;
    int bad   = 0;

    sum_frame_accumulator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .frame_len   (frame_len),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_acc     (out_acc),
        .out_count   (out_count),
        .out_ovf     (out_ovf),
        .o_dbg_state (o_dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  len;
        int          nbeats;
        logic [16:0] b0;
        logic [16:0] b1;
        logic [16:0] b2;
        logic [23:0] exp_acc;
        logic [7:0]  exp_cnt;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Beats after index 1 reuse b2; frame_len is perturbed after the first
    // beat to show the latched length is the one used.
    task automatic run_frame(input vec_t v, input int idx);
        for (int i = 0; i < v.nbeats; i++) begin
            @(negedge clk);
            if (i == 0) chk($sformatf("v%0d_in_ready_first", idx), 32'(in_ready), 32'd1);
            in_valid  = 1'b1;
            in_data   = (i == 0) ? v.b0 : (i == 1) ? v.b1 : v.b2;
            frame_len = (i == 0) ? v.len : 8'd1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("v%0d_out_valid", idx), 32'(out_valid), 32'd1);
        chk($sformatf("v%0d_in_ready_hold", idx), 32'(in_ready), 32'd0);
        chk($sformatf("v%0d_acc", idx), 32'(out_acc), 32'(v.exp_acc));
        chk($sformatf("v%0d_count", idx), 32'(out_count), 32'(v.exp_cnt));
        chk($sformatf("v%0d_ovf", idx), 32'(out_ovf), 32'(v.exp_ovf));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk($sformatf("v%0d_out_valid_done", idx), 32'(out_valid), 32'd0);
        chk($sformatf("v%0d_in_ready_done", idx), 32'(in_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{len: 8'd3,   nbeats: 3,   b0: 17'h00001, b1: 17'h1FFFF, b2: 17'h00010,
                    exp_acc: 24'h020010, exp_cnt: 8'd3, exp_ovf: 1'b0};
        vecs[1] = '{len: 8'd0,   nbeats: 1,   b0: 17'h00005, b1: 17'h0, b2: 17'h0,
                    exp_acc: 24'h000005, exp_cnt: 8'd1, exp_ovf: 1'b0};
        vecs[2] = '{len: 8'd2,   nbeats: 2,   b0: 17'h1FFFF, b1: 17'h1FFFF, b2: 17'h0,
                    exp_acc: 24'h03FFFE, exp_cnt: 8'd2, exp_ovf: 1'b0};
`ifdef SUM_ACC_SATURATE_EN
        vecs[3] = '{len: 8'hFF,  nbeats: 255, b0: 17'h1FFFF, b1: 17'h1FFFF, b2: 17'h1FFFF,
                    exp_acc: 24'hFFFFFF, exp_cnt: 8'd255, exp_ovf: 1'b1};
`else
        vecs[3] = '{len: 8'hFF,  nbeats: 255, b0: 17'h1FFFF, b1: 17'h1FFFF, b2: 17'h1FFFF,
                    exp_acc: 24'hFDFF01, exp_cnt: 8'd255, exp_ovf: 1'b1};
`endif
        vecs[4] = '{len: 8'd1,   nbeats: 1,   b0: 17'h1FFFF, b1: 17'h0, b2: 17'h0,
                    exp_acc: 24'h01FFFF, exp_cnt: 8'd1, exp_ovf: 1'b0};
        vecs[5] = '{len: 8'd4,   nbeats: 4,   b0: 17'h10000, b1: 17'h10000, b2: 17'h00001,
                    exp_acc: 24'h020002, exp_cnt: 8'd4, exp_ovf: 1'b0};

        // Reset state
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_acc", 32'(out_acc), 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_ovf", 32'(out_ovf), 32'd0);
        chk("rst_state", 32'(o_dbg_state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

        // Input gap inside ACCUM, then output backpressure with in_valid high
        @(negedge clk);
        in_valid = 1'b1; in_data = 17'h00100; frame_len = 8'd2;
        @(negedge clk);
        in_valid = 1'b0; in_data = 17'h1FFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("gap_out_valid", 32'(out_valid), 32'd0);
            chk("gap_in_ready", 32'(in_ready), 32'd1);
            chk("gap_state", 32'(o_dbg_state), 32'(ACCUM));
        end
        in_valid = 1'b1; in_data = 17'h00023;
        @(negedge clk);
        in_data = 17'h1FFFF;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_acc", 32'(out_acc), 32'h000123);
            chk("bp_count", 32'(out_count), 32'd2);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        chk("bp_in_ready_after", 32'(in_ready), 32'd1);
        chk("bp_out_valid_after", 32'(out_valid), 32'd0);
        chk("bp_acc_visible", 32'(out_acc), 32'h000123);

        // Clear collides with an accepted beat in ACCUM
        @(negedge clk);
        in_valid = 1'b1; in_data = 17'h00100; frame_len = 8'd3;
        @(negedge clk);
        in_data = 17'h00200; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_acc", 32'(out_acc), 32'd0);
        chk("clr_count", 32'(out_count), 32'd0);
        chk("clr_ovf", 32'(out_ovf), 32'd0);
        chk("clr_state", 32'(o_dbg_state), 32'(IDLE));
        in_valid = 1'b1; in_data = 17'h00007; frame_len = 8'd1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("clr_next_valid", 32'(out_valid), 32'd1);
        chk("clr_next_acc", 32'(out_acc), 32'd7);
        chk("clr_next_count", 32'(out_count), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Asynchronous reset mid-ACCUM, asserted away from any clock edge
        in_valid = 1'b1; in_data = 17'h00055; frame_len = 8'd3;
        @(negedge clk);
        in_data = 17'h00066;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_acc", 32'(out_acc), 32'd0);
        chk("arst_ovf", 32'(out_ovf), 32'd0);
        chk("arst_count", 32'(out_count), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
